midi_tx: RTL

//  Serial MIDI transmitter: takes one complete MIDI message per handshake and sends it as

---
 rtl/midi_tx_pkg.sv | 47 ++++
 rtl/midi_tx_uart_tx_byte.sv | 95 +++++++++
 rtl/midi_tx.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/midi_tx_pkg.sv
// Shared MIDI transmit definitions: line rate, message lengths, status class masks and FSM state types.
package midi_tx_pkg;

    localparam int unsigned MIDI_BAUD     = 31_250;
    localparam int unsigned MIDI_BYTES_CH = 3;
    localparam int unsigned MIDI_BYTES_PC = 2;

    localparam logic [7:0] MIDI_CLASS_MASK = 8'hF0;
    localparam logic [7:0] MIDI_PC_MASK    = 8'hE0;
    localparam logic [7:0] MIDI_CLASS_PC   = 8'hC0;
    localparam logic [7:0] MIDI_CLASS_SYS  = 8'hF0;
    localparam logic [7:0] MIDI_RT_MASK    = 8'hF8;

    typedef enum logic [2:0] {
        MSG_IDLE,
        MSG_SEND_STATUS,
        MSG_SEND_D1,
        MSG_SEND_D2,
        MSG_DONE
    } msg_state_t;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_START,
        SER_DATA,
        SER_STOP
    } ser_state_t;

    // 0xC0-0xDF carry one data byte, 0xF0-0xFF none, all other status bytes two.
    function automatic logic [1:0] midi_msg_len(input logic [7:0] status);
        if ((status & MIDI_CLASS_MASK) == MIDI_CLASS_SYS)
            return 2'd1;
        else if ((status & MIDI_PC_MASK) == MIDI_CLASS_PC)
            return 2'(MIDI_BYTES_PC);
        else
            return 2'(MIDI_BYTES_CH);
    endfunction

    function automatic logic midi_is_channel(input logic [7:0] status);
        return status[7] && ((status & MIDI_CLASS_MASK) != MIDI_CLASS_SYS);
    endfunction

    function automatic logic midi_is_realtime(input logic [7:0] status);
        return (status & MIDI_RT_MASK) == MIDI_RT_MASK;
    endfunction

endpackage

// File: rtl/midi_tx_uart_tx_byte.sv
// UART 8N1 byte serializer: START, BIT0..7, STOP, each BAUD_DIV cycles, LSB first, idle high.
module uart_tx_byte
    import midi_tx_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 320
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [7:0] data_i,
    output logic       ready_o,
    output logic       txData_o
);

    localparam int unsigned     CNT_W    = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

    ser_state_t       r_state, w_state_nx;
    logic [CNT_W-1:0] r_baud_cnt, w_baud_cnt_nx;
    logic [2:0]       r_bit_cnt, w_bit_cnt_nx;
    logic [7:0]       r_shift, w_shift_nx;
    logic             w_bit_end;

    assign w_bit_end = (r_baud_cnt == CNT_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= SER_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_baud_cnt <= w_baud_cnt_nx;
            r_bit_cnt  <= w_bit_cnt_nx;
            r_shift    <= w_shift_nx;
        end
    end

    // Ready is raised during the final stop-bit cycle so a new start bit follows with no gap.
    always_comb begin
        w_state_nx    = r_state;
        w_baud_cnt_nx = r_baud_cnt + 1'b1;
        w_bit_cnt_nx  = r_bit_cnt;
        w_shift_nx    = r_shift;
        ready_o       = 1'b0;
        txData_o      = 1'b1;
        case (r_state)
            SER_IDLE: begin
                ready_o       = 1'b1;
                w_baud_cnt_nx = '0;
                if (start_i) begin
                    w_state_nx = SER_START;
                    w_shift_nx = data_i;
                end
            end
            SER_START: begin
                txData_o = 1'b0;
                if (w_bit_end) begin
                    w_state_nx    = SER_DATA;
                    w_baud_cnt_nx = '0;
                    w_bit_cnt_nx  = '0;
                end
            end
            SER_DATA: begin
                txData_o = r_shift[0];
                if (w_bit_end) begin
                    w_baud_cnt_nx = '0;
                    w_shift_nx    = {1'b0, r_shift[7:1]};
                    if (r_bit_cnt == 3'd7)
                        w_state_nx = SER_STOP;
                    else
                        w_bit_cnt_nx = r_bit_cnt + 3'd1;
                end
            end
            SER_STOP: begin
                if (w_bit_end) begin
                    ready_o       = 1'b1;
                    w_baud_cnt_nx = '0;
                    if (start_i) begin
                        w_state_nx = SER_START;
                        w_shift_nx = data_i;
                    end else begin
                        w_state_nx = SER_IDLE;
                    end
                end
            end
            default: begin
                w_state_nx    = SER_IDLE;
                w_baud_cnt_nx = '0;
            end
        endcase
    end

endmodule

// File: rtl/midi_tx.sv
// MIDI message transmitter (UART 8N1). Optional running status via `define MIDI_RUNNING_STATUS_EN.
module midi_tx
    import midi_tx_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 10_000_000,
    parameter int unsigned BAUD     = MIDI_BAUD
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       msgValid_i,
    output logic       msgReady_o,
    input  logic [7:0] status_i,
    input  logic [7:0] data1_i,
    input  logic [7:0] data2_i,
    output logic       txData_o,
    output logic       busy_o,
    output logic       msgDone_o,
    output logic       err_o
);

    localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD;

    msg_state_t r_state, w_state_nx;
    logic [7:0] r_d1, r_d2;
    logic [1:0] r_len;
    logic       r_err;
    logic       w_accept;
    logic       w_skip_status;
    logic       w_ser_start;
    logic       w_ser_ready;
    logic [7:0] w_ser_data;
    logic [7:0] w_d1_in, w_d2_in;

    assign msgReady_o = (r_state == MSG_IDLE) || (r_state == MSG_DONE);
    assign busy_o     = !msgReady_o;
    assign msgDone_o  = (r_state == MSG_DONE);
    assign err_o      = r_err;
    assign w_accept   = msgValid_i && msgReady_o;
    assign w_d1_in    = data1_i & 8'h7F;
    assign w_d2_in    = data2_i & 8'h7F;

`ifdef MIDI_RUNNING_STATUS_EN
    logic [7:0] r_rs_status;
    logic       r_rs_valid;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rs_status <= '0;
            r_rs_valid  <= 1'b0;
        end else if (w_accept && status_i[7]) begin
            if (midi_is_channel(status_i)) begin
                r_rs_status <= status_i;
                r_rs_valid  <= 1'b1;
            end else if (!midi_is_realtime(status_i)) begin
                r_rs_valid  <= 1'b0;
            end
        end
    end

    assign w_skip_status = r_rs_valid && midi_is_channel(status_i) && (status_i == r_rs_status);
`else
    assign w_skip_status = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= MSG_IDLE;
            r_d1    <= '0;
            r_d2    <= '0;
            r_len   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_err   <= w_accept && !status_i[7];
            if (w_accept) begin
                r_d1  <= w_d1_in;
                r_d2  <= w_d2_in;
                r_len <= midi_msg_len(status_i);
            end
        end
    end

    // The first byte is handed to the serializer on the acceptance edge itself, so the
    // status byte never needs to be stored; later bytes are chained on serializer ready.
    always_comb begin
        w_state_nx  = r_state;
        w_ser_start = 1'b0;
        w_ser_data  = r_d1;
        case (r_state)
            MSG_IDLE, MSG_DONE: begin
                w_state_nx = MSG_IDLE;
                if (w_accept && status_i[7]) begin
                    w_ser_start = 1'b1;
                    if (w_skip_status) begin
                        w_ser_data = w_d1_in;
                        w_state_nx = MSG_SEND_D1;
                    end else begin
                        w_ser_data = status_i;
                        w_state_nx = MSG_SEND_STATUS;
                    end
                end
            end
            MSG_SEND_STATUS: begin
                if (w_ser_ready) begin
                    if (r_len == 2'd1) begin
                        w_state_nx = MSG_DONE;
                    end else begin
                        w_ser_start = 1'b1;
                        w_ser_data  = r_d1;
                        w_state_nx  = MSG_SEND_D1;
                    end
                end
            end
            MSG_SEND_D1: begin
                if (w_ser_ready) begin
                    if (r_len == 2'd3) begin
                        w_ser_start = 1'b1;
                        w_ser_data  = r_d2;
                        w_state_nx  = MSG_SEND_D2;
                    end else begin
                        w_state_nx = MSG_DONE;
                    end
                end
            end
            MSG_SEND_D2: begin
                if (w_ser_ready)
                    w_state_nx = MSG_DONE;
            end
            default: w_state_nx = MSG_IDLE;
        endcase
    end

    uart_tx_byte #(
        .BAUD_DIV(BAUD_DIV)
    ) u_uart_tx_byte (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (w_ser_start),
        .data_i  (w_ser_data),
        .ready_o (w_ser_ready),
        .txData_o(txData_o)
    );

endmodule
